prog_loader: RTL
================

Name: prog_loader

Overview:
- Byte-stream program loader that acts as the writing master of the MIPS instruction-memory programming interface.
- Takes a framed byte stream (UART-receiver style valid/ready), assembles big-endian 32-bit instruction words and writes them to sequential addresses via ProgMode/Addr_Prog/Data_Prog.
- After the last word it switches the core to run mode and pulses the core reset.
- Sits between the host-link receiver and the MIPS top.

Parameters:
- ADDR_W, 8, instruction-memory address width.
- DATA_W, 32, instruction width; fixed at 4 bytes per word.
- RST_CYCLES, 2, length in clocks of the core-reset pulse on release.
- TIMEOUT_CYC, 100000, maximum idle clocks between bytes inside a frame before abort.

Ports:
- clk, in, 1, system clock.
- reset, in, 1, synchronous active-high reset.
- start, in, 1, one-cycle pulse; re-enters load mode from RUN.
- rx_data, in, 8, incoming byte.
- rx_valid, in, 1, rx_data valid.
- rx_ready, out, 1, byte accepted when rx_valid && rx_ready at a rising edge.
- ProgMode, out, 1, 0 = program (write) mode, 1 = run mode; drives MIPS ProgMode.
- Addr_Prog, out, ADDR_W, write address.
- Data_Prog, out, DATA_W, write data.
- prog_we, out, 1, one-cycle write strobe; Addr_Prog/Data_Prog valid while high.
- cpu_reset, out, 1, drives MIPS reset.
- busy, out, 1, high in any state except RUN.
- err, out, 1, sticky timeout flag; cleared on the next accepted header byte or on reset.

Behaviour:
- Reset values: ProgMode=0, Addr_Prog=0, Data_Prog=0, prog_we=0, cpu_reset=1, rx_ready=0, busy=1, err=0, state=HDR.
- Frame format: 1 header byte N (word count; 0 means 2^ADDR_W words), then 4*N payload bytes, MSB first per word.
- HDR:
  - rx_ready=1, ProgMode=0, cpu_reset=1.
  - On accept: latch N, clear word counter, byte counter and address; clear err; go to COLLECT.
- COLLECT:
  - rx_ready=1; on each accept, shift: word <= {word[23:0], rx_data}.
  - After the 4th byte go to WRITE.
- WRITE (exactly 1 cycle):
  - rx_ready=0, prog_we=1, Addr_Prog=word index, Data_Prog=assembled word.
  - Next cycle: if index==N-1 (mod 2^ADDR_W), go to RELEASE; else increment address and return to COLLECT.
- RELEASE:
  - ProgMode=1, cpu_reset=1 for RST_CYCLES clocks, then go to RUN.
  - ProgMode and cpu_reset change on the same edge.
- RUN:
  - ProgMode=1, cpu_reset=0, rx_ready=0, busy=0.
  - Bytes are ignored.
  - start -> HDR (ProgMode=0, cpu_reset=1 on the next edge).
- Latency: 4th payload byte accepted at edge k -> prog_we high for cycle k+1 -> rx_ready high again at k+2.
  - Sustained rate is 1 word per 5 clocks when bytes arrive back to back.
- Timeout:
  - In COLLECT only; counter cleared on every accept.
  - Reaching TIMEOUT_CYC: err=1, discard the partial word, return to HDR.
  - Words already written stay written; the core stays in reset.
- Address wrap: Addr_Prog is ADDR_W bits; N=0 writes addresses 0..2^ADDR_W-1 and then releases. No write beyond the last index.
- start outside RUN is ignored.
- reset mid-frame: everything returns to reset values and state=HDR; a partial word is never written.
- prog_we is never high while ProgMode=1.

Decomposition:
- Shared package prog_pkg:
  - state encoding constants: HDR, COLLECT, WRITE, RELEASE, RUN;
  - BYTES_PER_WORD=4;
  - ADDR_W/DATA_W defaults, shared with the MIPS top.
- One natural sub-module, prog_word_asm: byte shifter plus 2-bit byte counter, emitting a word_done pulse.
- FSM, address counter, timeout counter and reset-pulse counter stay in prog_loader.

Test Plan:
- Header 0x02, bytes 12 34 56 78 AB CD EF 01 back to back:
  - prog_we at addr 0 with 0x12345678, then at addr 1 with 0xABCDEF01;
  - then ProgMode=1 with cpu_reset=1 for 2 clocks, then 0; busy=0.
- Same frame with rx_valid toggling randomly: identical writes and order; rx_ready=0 exactly on WRITE cycles.
- Header 0x01, 2 payload bytes, then silence for TIMEOUT_CYC (set to 50):
  - err=1, no prog_we, state=HDR;
  - a following valid frame writes correctly and clears err.
- Header 0x00 with 1024 bytes: 256 writes at addresses 0..255, then release; no 257th strobe.
- reset asserted after 3 payload bytes of word 1: no write of the partial word; outputs return to reset values; ProgMode=0, cpu_reset=1.
- In RUN, bytes offered: no accept. Then start pulse: ProgMode=0 and cpu_reset=1 next cycle; reload of 1 word to addr 0 succeeds.

Source files
------------

// File: rtl/prog_pkg.sv
// Shared definitions for the instruction-memory program loader.
// The MIPS top also uses these width defaults.
package prog_pkg;

  localparam int ADDR_W_DEF     = 8;
  localparam int DATA_W_DEF     = 32;
  localparam int BYTES_PER_WORD = 4;

  typedef enum logic [2:0] {
    HDR,
    COLLECT,
    WRITE,
    RELEASE,
    RUN
  } state_e;

endpackage

// File: rtl/prog_word_asm.sv
// Big-endian word assembler: shifts accepted bytes in MSB first and flags the
// byte that completes a word.
module prog_word_asm
  import prog_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clear_i,
  input  logic              accept_i,
  input  logic [7:0]        byte_i,
  output logic [DATA_W-1:0] word_o,
  output logic              word_done_o
);

  localparam int CNT_W = $clog2(BYTES_PER_WORD);

  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [DATA_W-9:0] shift_q, shift_d;

  // word_o already includes the byte on the bus, so the loader can latch the
  // finished word on the same edge that accepts the final byte.
  assign word_o      = {shift_q, byte_i};
  assign word_done_o = accept_i && (cnt_q == CNT_W'(BYTES_PER_WORD - 1));
  assign shift_d     = word_o[DATA_W-9:0];

  always_comb begin
    cnt_d = cnt_q;
    if (accept_i) begin
      cnt_d = word_done_o ? '0 : cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset || clear_i) begin
      cnt_q   <= '0;
      shift_q <= '0;
    end else if (accept_i) begin
      cnt_q   <= cnt_d;
      shift_q <= shift_d;
    end
  end

endmodule

// File: rtl/prog_loader.sv
// Byte-stream program loader: writes framed big-endian words into instruction
// memory, then releases the MIPS core from reset into run mode.
module prog_loader
  import prog_pkg::*;
#(
  parameter int ADDR_W      = ADDR_W_DEF,
  parameter int DATA_W      = DATA_W_DEF,
  parameter int RST_CYCLES  = 2,
  parameter int TIMEOUT_CYC = 100000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  output logic              rx_ready,
  output logic              ProgMode,
  output logic [ADDR_W-1:0] Addr_Prog,
  output logic [DATA_W-1:0] Data_Prog,
  output logic              prog_we,
  output logic              cpu_reset,
  output logic              busy,
  output logic              err
);

  localparam int TO_W = $clog2(TIMEOUT_CYC + 1);
  localparam int RC_W = $clog2(RST_CYCLES + 1);

  state_e            state_q;
  logic [ADDR_W-1:0] n_q;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] data_q;
  logic [TO_W-1:0]   to_cnt_q, to_cnt_d;
  logic [RC_W-1:0]   rst_cnt_q;
  logic              rx_ready_q;
  logic              prog_mode_q;
  logic              prog_we_q;
  logic              cpu_reset_q;
  logic              busy_q;
  logic              err_q;

  logic              accept;
  logic              hdr_accept;
  logic              col_accept;
  logic              to_expire;
  logic              last_word;
  logic              asm_done;
  logic [DATA_W-1:0] asm_word;

  assign accept     = rx_valid && rx_ready_q;
  assign hdr_accept = accept && (state_q == HDR);
  assign col_accept = accept && (state_q == COLLECT);
  assign to_expire  = (state_q == COLLECT) && !accept &&
                      (to_cnt_q == TO_W'(TIMEOUT_CYC - 1));
  // N is taken modulo 2^ADDR_W, so a header of 0 makes the last index all ones.
  assign last_word  = (addr_q == n_q - ADDR_W'(1));
  assign addr_d     = addr_q + ADDR_W'(1);
  assign to_cnt_d   = col_accept ? '0 : to_cnt_q + 1'b1;

  // An aborted frame must not leak stale bytes into the next frame's words.
  prog_word_asm #(
    .DATA_W(DATA_W)
  ) u_word_asm (
    .clk        (clk),
    .reset      (reset),
    .clear_i    (hdr_accept || to_expire),
    .accept_i   (col_accept),
    .byte_i     (rx_data),
    .word_o     (asm_word),
    .word_done_o(asm_done)
  );

  // Every output is a register, loaded with the value belonging to the state
  // being entered, so outputs change on the same edge as the state.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= HDR;
      n_q         <= '0;
      addr_q      <= '0;
      data_q      <= '0;
      to_cnt_q    <= '0;
      rst_cnt_q   <= '0;
      rx_ready_q  <= 1'b0;
      prog_mode_q <= 1'b0;
      prog_we_q   <= 1'b0;
      cpu_reset_q <= 1'b1;
      busy_q      <= 1'b1;
      err_q       <= 1'b0;
    end else begin
      prog_we_q <= 1'b0;
      case (state_q)
        HDR: begin
          rx_ready_q <= 1'b1;
          if (hdr_accept) begin
            n_q      <= ADDR_W'(rx_data);
            addr_q   <= '0;
            to_cnt_q <= '0;
            err_q    <= 1'b0;
            state_q  <= COLLECT;
          end
        end
        COLLECT: begin
          if (asm_done) begin
            rx_ready_q <= 1'b0;
            prog_we_q  <= 1'b1;
            data_q     <= asm_word;
            to_cnt_q   <= '0;
            state_q    <= WRITE;
          end else if (to_expire) begin
            err_q    <= 1'b1;
            to_cnt_q <= '0;
            state_q  <= HDR;
          end else begin
            to_cnt_q <= to_cnt_d;
          end
        end
        WRITE: begin
          if (last_word) begin
            prog_mode_q <= 1'b1;
            rst_cnt_q   <= '0;
            state_q     <= RELEASE;
          end else begin
            addr_q     <= addr_d;
            rx_ready_q <= 1'b1;
            state_q    <= COLLECT;
          end
        end
        RELEASE: begin
          if (rst_cnt_q == RC_W'(RST_CYCLES - 1)) begin
            cpu_reset_q <= 1'b0;
            busy_q      <= 1'b0;
            state_q     <= RUN;
          end else begin
            rst_cnt_q <= rst_cnt_q + 1'b1;
          end
        end
        RUN: begin
          if (start) begin
            prog_mode_q <= 1'b0;
            cpu_reset_q <= 1'b1;
            busy_q      <= 1'b1;
            rx_ready_q  <= 1'b1;
            state_q     <= HDR;
          end
        end
        default: begin
          state_q <= HDR;
        end
      endcase
    end
  end

  assign rx_ready  = rx_ready_q;
  assign ProgMode  = prog_mode_q;
  assign Addr_Prog = addr_q;
  assign Data_Prog = data_q;
  assign prog_we   = prog_we_q;
  assign cpu_reset = cpu_reset_q;
  assign busy      = busy_q;
  assign err       = err_q;

endmodule
